sub_byte_iter: RTL and testbench

Iterative, parametrised SubBytes engine for the AES-128 datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES shared SBox instances. It supports the forward and inverse S-box, selected per block. It returns the substituted state over a second valid/ready handshake. The LANES parameter trades area against latency for the iterative round core.

---
 rtl/sub_byte_iter_pkg.sv | 73 +++++++
 rtl/sub_byte_iter_sbox.sv | 27 ++
 rtl/sub_byte_iter.sv | 123 ++++++++++++
 tb/tb_sub_byte_iter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_byte_iter_pkg.sv
// ---------------------------------------------------------------------------
// sub_byte_iter_pkg
// Shared AES definitions for the iterative SubBytes engine: state geometry,
// FSM state encoding, the legal-LANES check and GF(2^8) helper functions
// used by the S-box.
// ---------------------------------------------------------------------------
package sub_byte_iter_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // LANES must divide the 16-byte state into whole chunks.
    function automatic bit lanes_legal(input int lanes);
        case (lanes)
            1, 2, 4, 8, 16: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int k);
        return 8'((a << k) | (a >> (8 - k)));
    endfunction

    // Forward S-box affine transform applied after inversion.
    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    // Inverse affine transform applied before inversion.
    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        return rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/sub_byte_iter_sbox.sv
// ---------------------------------------------------------------------------
// sub_byte_iter_sbox
// Combinational AES S-box, forward or inverse selected per call.
// Ports:
//   din  - input byte
//   dec  - 1 selects the inverse S-box, 0 the forward S-box
//   dout - substituted byte
// ---------------------------------------------------------------------------
module sub_byte_iter_sbox
    import sub_byte_iter_pkg::*;
(
    input  logic [7:0] din,
    input  logic       dec,
    output logic [7:0] dout
);

    // Forward: affine(inverse(x)); inverse: inverse(affine^-1(x)).
    always_comb begin
        dout = 8'h00;
        if (dec) begin
            dout = gf_inv(affine_inv(din));
        end else begin
            dout = affine_fwd(gf_inv(din));
        end
    end

endmodule

// File: rtl/sub_byte_iter.sv
// ---------------------------------------------------------------------------
// sub_byte_iter
// Iterative SubBytes engine: accepts a 128-bit AES state, substitutes LANES
// bytes per cycle through LANES shared S-boxes, and returns the result over
// a valid/ready handshake. The latched direction bit selects forward or
// inverse S-box for the whole block.
// Ports:
//   i_Clk   - rising-edge clock
//   i_Rst   - asynchronous active-high reset
//   i_Valid - input block valid          o_Ready - engine can accept a block
//   i_Data  - input state (byte k at [k*8+:8])
//   i_fDec  - 1 = inverse S-box, sampled on accept
//   o_Valid - result valid               i_Ready - downstream accepts result
//   o_Data  - substituted state (byte k at [k*8+:8])
//   o_Busy  - high while substituting
// ---------------------------------------------------------------------------
module sub_byte_iter
    import sub_byte_iter_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [AES_STATE_W-1:0] i_Data,
    input  logic                   i_fDec,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [AES_STATE_W-1:0] o_Data,
    output logic                   o_Busy
);

    localparam int CHUNKS = AES_BYTES / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int LW     = LANES * 8;
    localparam int SHIFT  = $clog2(LW);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sub_byte_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic                   dec_r;
    logic [AES_STATE_W-1:0] data_r;

    logic [6:0]             base_s;
    logic [LW-1:0]          chunk_in_s;
    logic [LW-1:0]          chunk_out_s;

    // Bit offset of the current chunk; a shift keeps the select width exact.
    always_comb begin
        base_s     = 7'(cnt_r) << SHIFT;
        chunk_in_s = data_r[base_s +: LW];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sub_byte_iter_sbox u_sbox (
            .din  (chunk_in_s[g*8 +: 8]),
            .dec  (dec_r),
            .dout (chunk_out_s[g*8 +: 8])
        );
    end

    assign o_Data = data_r;

    // Control FSM, chunk counter, state register and registered handshake outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dec_r   <= 1'b0;
            data_r  <= '0;
            o_Valid <= 1'b0;
            o_Ready <= 1'b0;
            o_Busy  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // o_Ready is low for the first cycle out of reset, so the
                    // handshake must qualify on it rather than on the state alone.
                    if (i_Valid && o_Ready) begin
                        data_r  <= i_Data;
                        dec_r   <= i_fDec;
                        cnt_r   <= '0;
                        state_r <= BUSY;
                        o_Ready <= 1'b0;
                        o_Busy  <= 1'b1;
                    end else begin
                        o_Ready <= 1'b1;
                    end
                end
                BUSY: begin
                    data_r[base_s +: LW] <= chunk_out_s;
                    if (cnt_r == CW'(CHUNKS - 1)) begin
                        state_r <= DONE;
                        o_Busy  <= 1'b0;
                        o_Valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        state_r <= IDLE;
                        o_Valid <= 1'b0;
                        o_Ready <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_Valid <= 1'b0;
                    o_Ready <= 1'b0;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_byte_iter.sv
// ---------------------------------------------------------------------------
// tb_sub_byte_iter
// Directed bench for sub_byte_iter. One instance per legal LANES value
// (index i has LANES = 1 << i). The random stream is scored against a
// table-driven S-box model built by a generator-walk algorithm.
// ---------------------------------------------------------------------------
module tb_sub_byte_iter;

    localparam int NDUT = 5;

    localparam logic [127:0] V_PLAIN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SUB   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V_63    = {16{8'h63}};
    localparam logic [127:0] V_ZERO  = 128'h0;

    logic clk = 1'b0;
    logic rst;

    logic         valid_in  [NDUT];
    logic         ready_out [NDUT];
    logic [127:0] data_in   [NDUT];
    logic         dec_in    [NDUT];
    logic         valid_out [NDUT];
    logic         ready_in  [NDUT];
    logic [127:0] data_out  [NDUT];
    logic         busy_out  [NDUT];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_byte_iter #(.LANES(1 << g)) u_dut (
            .i_Clk   (clk),
            .i_Rst   (rst),
            .i_Valid (valid_in[g]),
            .o_Ready (ready_out[g]),
            .i_Data  (data_in[g]),
            .i_fDec  (dec_in[g]),
            .o_Valid (valid_out[g]),
            .i_Ready (ready_in[g]),
            .o_Data  (data_out[g]),
            .o_Busy  (busy_out[g])
        );
    end

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] a, input int k);
        return 8'((a << k) | (a >> (8 - k)));
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse in lockstep.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] d, input logic dec);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[k*8 +: 8] = dec ? inv_tab[d[k*8 +: 8]] : fwd_tab[d[k*8 +: 8]];
        return r;
    endfunction

    task automatic wait_ready(input int idx, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_out[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_rdy"}, 128'(ready_out[idx]), 128'(1));
    endtask

    // Present one block at a negedge and return #1 after the accept edge.
    task automatic accept_block(input int idx, input logic [127:0] din, input logic dec, input string tag);
        wait_ready(idx, tag);
        data_in[idx]  = din;
        dec_in[idx]   = dec;
        valid_in[idx] = 1'b1;
        @(posedge clk);
        #1;
        valid_in[idx] = 1'b0;
    endtask

    // Send a block, measure accept-to-valid latency and check the result.
    task automatic run_block(input int idx, input logic [127:0] din, input logic dec,
                             input logic [127:0] exp, input string tag, input bit scramble);
        int lat;
        bit got;
        accept_block(idx, din, dec, tag);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            if (scramble) begin
                data_in[idx] = {$urandom, $urandom, $urandom, $urandom};
                dec_in[idx]  = ~dec_in[idx];
            end
            @(posedge clk);
            #1;
            lat++;
            got = valid_out[idx];
        end
        check_value({tag, "_lat"}, 128'(lat), 128'(16 >> idx));
        check_value({tag, "_data"}, data_out[idx], exp);
    endtask

    task automatic stream(input int idx, input int n, input string tag);
        int rcv, guard, last_acc, chunks;
        rcv      = 0;
        last_acc = 0;
        chunks   = 16 >> idx;
        sb_q.delete();
        fork
            begin
                for (int b = 0; b < n; b++) begin
                    logic [127:0] d;
                    logic         dc;
                    int           w;
                    int           acc;
                    d  = {$urandom, $urandom, $urandom, $urandom};
                    dc = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    valid_in[idx] = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    data_in[idx]  = d;
                    dec_in[idx]   = dc;
                    valid_in[idx] = 1'b1;
                    w = 0;
                    while (!ready_out[idx] && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    check_value({tag, "_acc"}, 128'(ready_out[idx]), 128'(1));
                    @(posedge clk);
                    #1;
                    acc = cyc;
                    if (b > 0) check_value({tag, "_ii"}, 128'(acc - last_acc >= chunks + 2), 128'(1));
                    last_acc = acc;
                    sb_q.push_back(model_sub(d, dc));
                end
                @(negedge clk);
                valid_in[idx] = 1'b0;
            end
            begin
                guard = 0;
                while (rcv < n && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    ready_in[idx] = ($urandom_range(0, 3) != 0);
                    if (valid_out[idx] && ready_in[idx]) begin
                        if (sb_q.size() == 0) begin
                            check_value({tag, "_extra"}, 128'(1), 128'(0));
                        end else begin
                            check_value({tag, "_blk"}, data_out[idx], sb_q.pop_front());
                        end
                        rcv++;
                    end
                end
            end
        join
        ready_in[idx] = 1'b1;
        check_value({tag, "_count"}, 128'(rcv), 128'(n));
        check_value({tag, "_left"}, 128'(sb_q.size()), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        check_value({tag, "_quiet"}, 128'(valid_out[idx]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        build_tables();
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            valid_in[i] = 1'b0;
            data_in[i]  = '0;
            dec_in[i]   = 1'b0;
            ready_in[i] = 1'b1;
        end

        // Reset state
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check_value("rst_ready", 128'(ready_out[i]), 128'(0));
            check_value("rst_valid", 128'(valid_out[i]), 128'(0));
            check_value("rst_data",  data_out[i], V_ZERO);
            check_value("rst_busy",  128'(busy_out[i]), 128'(0));
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) check_value("idle_ready", 128'(ready_out[i]), 128'(1));

        // Forward substitution at every LANES value
        for (int i = 0; i < NDUT; i++) run_block(i, V_PLAIN, 1'b0, V_SUB, "fwd", 1'b0);

        // Inverse substitution and boundary patterns
        run_block(2, V_SUB, 1'b1, V_PLAIN, "inv", 1'b0);
        run_block(4, V_SUB, 1'b1, V_PLAIN, "inv16", 1'b0);
        run_block(2, V_63, 1'b1, V_ZERO, "inv63", 1'b0);
        run_block(1, V_ZERO, 1'b0, V_63, "fwd00", 1'b0);

        // Backpressure: hold DONE, ignore a new request, release
        ready_in[2] = 1'b0;
        run_block(2, V_PLAIN, 1'b0, V_SUB, "bp", 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                @(negedge clk);
                data_in[2]  = ~V_PLAIN;
                valid_in[2] = 1'b1;
            end
            if (i == 6) begin
                @(negedge clk);
                valid_in[2] = 1'b0;
            end
            @(posedge clk);
            #1;
            check_value("bp_valid", 128'(valid_out[2]), 128'(1));
            check_value("bp_data",  data_out[2], V_SUB);
            check_value("bp_ready", 128'(ready_out[2]), 128'(0));
        end
        @(negedge clk);
        ready_in[2] = 1'b1;
        @(posedge clk);
        #1;
        check_value("bp_rel_valid", 128'(valid_out[2]), 128'(0));
        check_value("bp_rel_ready", 128'(ready_out[2]), 128'(1));
        check_value("bp_rel_data",  data_out[2], V_SUB);
        run_block(2, V_63, 1'b1, V_ZERO, "bp_next", 1'b0);

        // Inputs changing while the block is in flight
        run_block(2, V_PLAIN, 1'b0, V_SUB, "mid4", 1'b1);
        run_block(0, V_SUB, 1'b1, V_PLAIN, "mid1", 1'b1);

        // Asynchronous reset in the middle of a LANES=1 block
        accept_block(0, V_PLAIN, 1'b0, "arst");
        repeat (5) @(posedge clk);
        #1;
        check_value("arst_busy_pre", 128'(busy_out[0]), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check_value("arst_valid", 128'(valid_out[0]), 128'(0));
        check_value("arst_data",  data_out[0], V_ZERO);
        check_value("arst_busy",  128'(busy_out[0]), 128'(0));
        check_value("arst_ready", 128'(ready_out[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_value("arst_rel_ready", 128'(ready_out[0]), 128'(1));
        check_value("arst_rel_valid", 128'(valid_out[0]), 128'(0));
        run_block(0, V_PLAIN, 1'b0, V_SUB, "arst_next", 1'b0);

        // Random back-to-back streams against the model
        stream(2, 100, "strm4");
        stream(4, 30, "strm16");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
